approx_sel_ctrl: RTL and testbench
==================================

// Module: approx_sel_ctrl
// PURPOSE
//   Window-based accuracy controller sitting directly upstream of the mux array that chooses
//   between exact (i) and approximate (j) multiplier results. For each window of WIN_LEN
//   operand pairs it forwards the operands through one register stage together with out_sel.
//   out_sel=1 selects the exact path and 0 selects the approximate path. The first cfg_exact_cnt
//   beats of a window are exact and the remaining beats are approximate.
// PARAMETERS
//   DW       8   operand width (in_a/in_b/out_a/out_b)
//   WIN_LEN  16  beats per window, >=1
//   CNT_W    5   width of beat index and cfg_exact_cnt; must satisfy 2**CNT_W > WIN_LEN
// PORTS
//   clk            in   1      rising-edge clock
//   rst_n          in   1      asynchronous active-low reset
//   start          in   1      1-cycle pulse; begins a window (sampled only in IDLE)
//   cfg_exact_cnt  in   CNT_W  exact beats per window, latched on accepted start
//   cfg_bypass     in   1      1 = whole window exact, latched on accepted start
//   in_valid       in   1      operand pair valid
//   in_ready       out  1      block can accept a pair this cycle
//   in_a, in_b     in   DW     operands
//   out_valid      out  1      registered pair valid
//   out_ready      in   1      downstream accepts the pair
//   out_a, out_b   out  DW     registered operands
//   out_sel        out  1      mux select for this pair (1 exact, 0 approx)
//   out_last       out  1      pair is the final beat of the window
//   busy           out  1      state != IDLE, or out_valid=1
//   done           out  1      1-cycle pulse on the cycle the last beat is accepted at the output
// BEHAVIOUR
//   Reset: state=IDLE, idx=0, latched cfg=0; out_valid/out_sel/out_last/done/busy=0;
//     out_a/out_b=0. Asserting rst_n low mid-window discards the window and any held pair.
//   FSM states: IDLE, EXACT, APPROX.
//     IDLE: on start, latch cfg, set idx=0, then go to
//       - EXACT if cfg_bypass=1 or cfg_exact_cnt!=0;
//       - APPROX otherwise.
//       start is ignored outside IDLE.
//     EXACT -> APPROX: on accepting the beat with idx==cfg_exact_cnt-1, unless bypass=1 or
//       cfg_exact_cnt>=WIN_LEN.
//     EXACT/APPROX -> IDLE: on accepting the beat with idx==WIN_LEN-1; that beat carries
//       out_last=1. This takes priority over the EXACT->APPROX transition.
//   Handshake
//     in_ready = (state!=IDLE) && (!out_valid || out_ready). This is the full-throughput
//       single-stage pipe.
//     A beat is accepted when in_valid && in_ready. On the next edge:
//       out_a/out_b <= in_a/in_b; out_sel <= (state==EXACT); out_last <= (idx==WIN_LEN-1);
//       out_valid <= 1; idx <= idx+1 (or 0 on the last beat).
//     If no beat is accepted and out_ready=1, out_valid <= 0 on the next edge.
//     If out_valid=1 && out_ready=0, out_a/out_b/out_sel/out_last are held stable.
//   Latency: 1 cycle from input acceptance to out_valid. Throughput: 1 beat/cycle.
//   done=1 for exactly one cycle, the cycle where out_valid && out_ready && out_last.
//   Back-to-back windows: start may be asserted in the cycle after the return to IDLE.
//     The final beat may still be held at the output at that point; in_ready stays 0 until
//     the new window's state is entered.
//   idx never wraps past WIN_LEN-1. cfg inputs changing mid-window have no effect.
// TESTING
//   1. WIN_LEN=16, cfg_exact_cnt=4, bypass=0, in_valid=1 and out_ready=1 continuously
//      -> out_sel=1 on beats 0..3 and 0 on beats 4..15; out_last and done on beat 15;
//         16 consecutive out_valid cycles.
//   2. cfg_exact_cnt=0 -> all 16 beats have out_sel=0.
//      cfg_exact_cnt=20, or bypass=1 with cnt=2 -> all 16 beats have out_sel=1.
//   3. Stall: out_ready=0 for 3 cycles at beat 5 -> in_ready=0 and out_a/out_b/out_sel held
//      for those cycles; no beat lost or duplicated; order preserved.
//   4. Pulse start while in EXACT -> ignored, idx unchanged.
//      Then pulse start in IDLE with in_valid=0 -> in_ready=1 with no out_valid.
//   5. Drive rst_n low at beat 7, release, restart with cnt=3
//      -> outputs reach reset values asynchronously; the new window begins at idx=0.
//   6. Randomised in_valid/out_ready over 4 windows with a scoreboard
//      -> sel pattern per window matches cnt; exactly 4 done pulses.

Source files
------------

// File: rtl/approx_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : approx_sel_ctrl
// Purpose  : Window-based accuracy controller placed in front of the
//            exact/approximate multiplier mux array. Each window of WIN_LEN
//            operand pairs passes through a single register stage. The first
//            cfg_exact_cnt beats of a window are tagged exact (out_sel=1) and
//            the remaining beats approximate (out_sel=0). cfg_bypass forces
//            the whole window to be exact.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            start               - begins a window (sampled only in IDLE)
//            cfg_exact_cnt       - exact beats per window (latched on start)
//            cfg_bypass          - whole window exact (latched on start)
//            in_valid/in_ready   - upstream handshake
//            in_a, in_b          - operands
//            out_valid/out_ready - downstream handshake
//            out_a, out_b        - registered operands
//            out_sel             - 1 exact, 0 approximate
//            out_last            - final beat of the window
//            busy                - window active or output pair pending
//            done                - final beat accepted downstream this cycle
// Revision : 1.0 - initial release
// ============================================================================
module approx_sel_ctrl #(
    parameter int DW      = 8,
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_exact_cnt,
    input  logic             cfg_bypass,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_a,
    input  logic [DW-1:0]    in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_a,
    output logic [DW-1:0]    out_b,
    output logic             out_sel,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXACT  = 2'd1;
    localparam logic [1:0] S_APPROX = 2'd2;

    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] c_win_len  = CNT_W'(WIN_LEN);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cfg_cnt;
    logic             r_cfg_bypass;

    logic             r_out_valid;
    logic [DW-1:0]    r_out_a;
    logic [DW-1:0]    r_out_b;
    logic             r_out_sel;
    logic             r_out_last;

    logic             w_start_acc;
    logic             w_accept;
    logic             w_last_beat;
    logic             w_exact_end;

    // Single-stage pipe: a new pair may enter whenever the output register
    // is empty or being drained in the same cycle.
    assign in_ready    = (r_state != S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_last_beat = (r_idx == c_last_idx);

    // Leaving the exact phase early only applies when the exact count is
    // smaller than the window; otherwise the whole window stays exact.
    assign w_exact_end = !r_cfg_bypass && (r_cfg_cnt < c_win_len) &&
                         (r_idx == (r_cfg_cnt - c_one));

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    if (cfg_bypass || (cfg_exact_cnt != '0)) begin
                        w_state_nxt = S_EXACT;
                    end else begin
                        w_state_nxt = S_APPROX;
                    end
                end
            end
            S_EXACT: begin
                if (w_accept) begin
                    // End of window wins over the exact->approx switch.
                    if (w_last_beat) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_exact_end) begin
                        w_state_nxt = S_APPROX;
                    end
                end
            end
            S_APPROX: begin
                if (w_accept && w_last_beat) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_cfg_cnt    <= '0;
            r_cfg_bypass <= 1'b0;
        end else if (w_start_acc) begin
            r_idx        <= '0;
            r_cfg_cnt    <= cfg_exact_cnt;
            r_cfg_bypass <= cfg_bypass;
        end else if (w_accept) begin
            r_idx <= w_last_beat ? '0 : (r_idx + c_one);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_sel   <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_a     <= in_a;
            r_out_b     <= in_b;
            r_out_sel   <= (r_state == S_EXACT);
            r_out_last  <= w_last_beat;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_sel   = r_out_sel;
    assign out_last  = r_out_last;
    assign busy      = (r_state != S_IDLE) || r_out_valid;
    assign done      = r_out_valid && out_ready && r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_approx_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_sel_ctrl
// Purpose  : Self-checking bench for approx_sel_ctrl. A window-level model
//            (beat counter plus a queue of pairs in flight) predicts every
//            output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_sel_ctrl;

    localparam int DW      = 8;
    localparam int WIN_LEN = 16;
    localparam int CNT_W   = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] cfg_exact_cnt = '0;
    logic             cfg_bypass = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_a = '0;
    logic [DW-1:0]    in_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    out_a;
    logic [DW-1:0]    out_b;
    logic             out_sel;
    logic             out_last;
    logic             busy;
    logic             done;

    approx_sel_ctrl #(.DW(DW), .WIN_LEN(WIN_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_exact_cnt(cfg_exact_cnt), .cfg_bypass(cfg_bypass),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_sel(out_sel), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        bit            sel;
        bit            last;
        int            idx;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    done_seen = 0;

    bit    m_active = 0;
    int    m_k = 0;
    int    m_cnt = 0;
    bit    m_bypass = 0;
    int    req_cnt = 0;
    bit    req_bypass = 0;

    // One clock cycle: drive at negedge, check predictions 1 time unit later,
    // then advance the model as the coming rising edge will.
    task automatic cycle(input bit st, input bit v, input bit rdy);
        bit ir_exp, ov_exp, done_exp, busy_exp, was_active;
        beat_t nb;
        @(negedge clk);
        start    = st;
        in_valid = v;
        in_a     = DW'($urandom);
        in_b     = DW'($urandom);
        out_ready = rdy;
        if (st) begin
            cfg_exact_cnt = CNT_W'(req_cnt);
            cfg_bypass    = req_bypass;
        end else begin
            cfg_exact_cnt = CNT_W'($urandom_range(0, 31));
            cfg_bypass    = 1'($urandom_range(0, 1));
        end
        #1;
        ov_exp   = (sb.size() != 0);
        ir_exp   = m_active && (!ov_exp || rdy);
        busy_exp = m_active || ov_exp;
        done_exp = ov_exp && rdy && sb[0].last;
        checks++;
        if (out_valid !== ov_exp) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b", out_valid, ov_exp);
        end
        checks++;
        if (in_ready !== ir_exp) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b", in_ready, ir_exp);
        end
        checks++;
        if (busy !== busy_exp) begin
            errors++;
            $display("FAIL busy: got %b expected %b", busy, busy_exp);
        end
        checks++;
        if (done !== done_exp) begin
            errors++;
            $display("FAIL done: got %b expected %b", done, done_exp);
        end
        if (done === 1'b1) done_seen++;
        if (ov_exp) begin
            checks++;
            if (out_a !== sb[0].a || out_b !== sb[0].b) begin
                errors++;
                $display("FAIL out_data beat %0d: got %h/%h expected %h/%h",
                         sb[0].idx, out_a, out_b, sb[0].a, sb[0].b);
            end
            checks++;
            if (out_sel !== sb[0].sel) begin
                errors++;
                $display("FAIL out_sel beat %0d: got %b expected %b", sb[0].idx, out_sel, sb[0].sel);
            end
            checks++;
            if (out_last !== sb[0].last) begin
                errors++;
                $display("FAIL out_last beat %0d: got %b expected %b", sb[0].idx, out_last, sb[0].last);
            end
        end
        was_active = m_active;
        if (ov_exp && rdy) void'(sb.pop_front());
        if (v && ir_exp) begin
            nb.a    = in_a;
            nb.b    = in_b;
            nb.sel  = m_bypass || (m_k < m_cnt);
            nb.last = (m_k == WIN_LEN - 1);
            nb.idx  = m_k;
            sb.push_back(nb);
            m_k++;
            if (m_k == WIN_LEN) m_active = 0;
        end
        if (st && !was_active) begin
            m_active = 1;
            m_k      = 0;
            m_cnt    = req_cnt;
            m_bypass = req_bypass;
        end
    endtask

    // Runs until the window has taken all its beats, then drains the output.
    task automatic run_full(input int cnt, input bit byp);
        int guard;
        int d0;
        d0 = done_seen;
        req_cnt = cnt;
        req_bypass = byp;
        cycle(1, 0, 1);
        guard = 0;
        while ((m_active || sb.size() != 0) && guard < 100) begin
            cycle(0, m_active, 1);
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL window_timeout cnt=%0d: got %0d cycles expected <100", cnt, guard);
        end
        checks++;
        if (done_seen - d0 != 1) begin
            errors++;
            $display("FAIL done_count cnt=%0d: got %0d expected 1", cnt, done_seen - d0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_sel, out_last, busy, done, in_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {out_valid, out_sel, out_last, busy, done, in_ready});
        end
        checks++;
        if ({out_a, out_b} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {out_a, out_b});
        end
        rst_n = 1'b1;
        cycle(0, 1, 1);
    endtask

    task automatic test_patterns();
        run_full(4, 0);
        run_full(0, 0);
        run_full(20, 0);
        run_full(2, 1);
        run_full(16, 0);
        run_full(15, 0);
    endtask

    task automatic test_stall();
        int guard;
        int stalls;
        req_cnt = 6;
        req_bypass = 0;
        cycle(1, 0, 1);
        guard = 0;
        stalls = 0;
        while ((m_active || sb.size() != 0) && guard < 100) begin
            if (sb.size() != 0 && sb[0].idx == 5 && stalls < 3) begin
                stalls++;
                cycle(0, m_active, 0);
            end else begin
                cycle(0, m_active, 1);
            end
            guard++;
        end
        checks++;
        if (guard >= 100 || stalls != 3) begin
            errors++;
            $display("FAIL stall_run: got guard=%0d stalls=%0d expected <100 and 3", guard, stalls);
        end
    endtask

    task automatic test_start_ignored();
        int guard;
        req_cnt = 8;
        req_bypass = 0;
        cycle(1, 0, 1);
        repeat (3) cycle(0, 1, 1);
        req_cnt = 0;
        req_bypass = 0;
        cycle(1, 1, 1);
        guard = 0;
        while ((m_active || sb.size() != 0) && guard < 100) begin
            cycle(0, m_active, 1);
            guard++;
        end
        req_cnt = 5;
        req_bypass = 0;
        cycle(1, 0, 1);
        #1;
        cycle(0, 0, 1);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_start_ready: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        guard = 0;
        while ((m_active || sb.size() != 0) && guard < 100) begin
            cycle(0, m_active, 1);
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL start_ignored_timeout: got %0d expected <100", guard);
        end
    endtask

    task automatic test_mid_reset();
        req_cnt = 5;
        req_bypass = 0;
        cycle(1, 0, 1);
        while (m_k < 7) cycle(0, 1, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_sel, out_last, busy, done, in_ready} !== 6'b0 || {out_a, out_b} !== '0) begin
            errors++;
            $display("FAIL async_reset: got flags=%b data=%h expected 0/0",
                     {out_valid, out_sel, out_last, busy, done, in_ready}, {out_a, out_b});
        end
        sb.delete();
        m_active = 0;
        m_k = 0;
        #2 rst_n = 1'b1;
        run_full(3, 0);
    endtask

    task automatic test_random();
        int guard;
        int d0;
        d0 = done_seen;
        guard = 0;
        for (int w = 0; w < 4; w++) begin
            req_cnt = $urandom_range(0, 20);
            req_bypass = ($urandom_range(0, 3) == 0);
            cycle(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            while (m_active && guard < 2000) begin
                cycle(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
                guard++;
            end
        end
        while (sb.size() != 0 && guard < 2000) begin
            cycle(0, 0, ($urandom_range(0, 1) != 0));
            guard++;
        end
        checks++;
        if (guard >= 2000) begin
            errors++;
            $display("FAIL random_timeout: got %0d expected <2000", guard);
        end
        checks++;
        if (done_seen - d0 != 4) begin
            errors++;
            $display("FAIL random_done_count: got %0d expected 4", done_seen - d0);
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_stall();
        test_start_ignored();
        test_mid_reset();
        test_random();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
